// File: rtl/window_ctrl_pkg.sv
// window_ctrl_pkg: state encoding and buffer geometry shared by the window buffer controller
package window_ctrl_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE      = 3'd0;
  localparam state_t LOAD_REQ  = 3'd1;
  localparam state_t LOAD_WAIT = 3'd2;
  localparam state_t SLIDE     = 3'd3;
  localparam state_t SHIFT     = 3'd4;
  localparam state_t DONE      = 3'd5;
  localparam int BUF_ROWS      = 4;
  localparam int WORDS_PER_ROW = 4;
  localparam int WIN_POSITIONS = 13;
  localparam int MAX_COL       = WIN_POSITIONS - 1;
endpackage

// File: rtl/window_addr_gen.sv
// window_addr_gen: memory word address and buffer write slot for the word being fetched
module window_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [7:0]        img_row_i,
  input  logic [1:0]        load_row_i,
  input  logic [1:0]        word_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [8:0]        wr_addr_o
);
  assign mem_addr_o = base_i + ADDR_W'({img_row_i, word_i});
  assign wr_addr_o  = {3'b000, load_row_i, word_i, 2'b00};
endmodule

// File: rtl/window_buffer_ctrl.sv
// window_buffer_ctrl: fills the 4-row window buffer from memory and steps 13 windows per band
// WINDOW_CTRL_PERF_EN adds saturating stall_cnt / memwait_cnt outputs
module window_buffer_ctrl
  import window_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_rows,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  output logic              buf_we,
  output logic              buf_shift_up,
  output logic [8:0]        buf_addr,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [3:0]        win_col,
  output logic [7:0]        win_row,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef WINDOW_CTRL_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       memwait_cnt
`endif
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, gen_addr;
  logic [7:0] rows_q, rows_d, band_q, band_d;
  logic [1:0] load_row_q, load_row_d, word_q, word_d;
  logic [3:0] col_q, col_d;
  logic err_q, err_d, accept;
  logic [8:0] wr_addr;
  assign accept = state_q == IDLE && start;
  // initial fill has band=0, refill has load_row=3, so band+load_row is the image row in both
  window_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .base_i    (base_q),
    .img_row_i (band_q + 8'(load_row_q)),
    .load_row_i(load_row_q),
    .word_i    (word_q),
    .mem_addr_o(gen_addr),
    .wr_addr_o (wr_addr)
  );
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    rows_d     = rows_q;
    band_d     = band_q;
    load_row_d = load_row_q;
    word_d     = word_q;
    col_d      = col_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (start) begin
        base_d     = base_addr;
        rows_d     = num_rows;
        band_d     = '0;
        load_row_d = '0;
        word_d     = '0;
        col_d      = '0;
        err_d      = num_rows < 8'(BUF_ROWS);
        state_d    = num_rows < 8'(BUF_ROWS) ? DONE : LOAD_REQ;
      end
      LOAD_REQ: state_d = LOAD_WAIT;
      LOAD_WAIT: if (mem_rvalid) begin
        word_d     = word_q + 2'd1;
        load_row_d = word_q == 2'(WORDS_PER_ROW - 1) && load_row_q != 2'(BUF_ROWS - 1) ? load_row_q + 2'd1 : load_row_q;
        col_d      = '0;
        state_d    = word_q == 2'(WORDS_PER_ROW - 1) && load_row_q == 2'(BUF_ROWS - 1) ? SLIDE : LOAD_REQ;
      end
      SLIDE: if (win_ready) begin
        col_d   = col_q == 4'(MAX_COL) ? 4'd0 : col_q + 4'd1;
        state_d = col_q != 4'(MAX_COL) ? SLIDE : band_q == rows_q - 8'(BUF_ROWS) ? DONE : SHIFT;
      end
      SHIFT: begin
        band_d  = band_q + 8'd1;
        state_d = LOAD_REQ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      rows_q     <= '0;
      band_q     <= '0;
      load_row_q <= '0;
      word_q     <= '0;
      col_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rows_q     <= rows_d;
      band_q     <= band_d;
      load_row_q <= load_row_d;
      word_q     <= word_d;
      col_q      <= col_d;
      err_q      <= err_d;
    end
  end
  assign mem_rd       = state_q == LOAD_REQ;
  assign mem_addr     = mem_rd ? gen_addr : '0;
  assign buf_we       = state_q == LOAD_WAIT && mem_rvalid;
  assign buf_shift_up = state_q == SHIFT;
  assign win_valid    = state_q == SLIDE;
  assign buf_addr     = buf_we ? wr_addr : win_valid ? {5'b0, col_q} : 9'd0;
  assign win_col      = col_q;
  assign win_row      = band_q;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
  assign err          = err_q;
`ifdef WINDOW_CTRL_PERF_EN
  logic [15:0] stall_q, memwait_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      memwait_q <= '0;
    end else if (accept) begin
      stall_q   <= '0;
      memwait_q <= '0;
    end else begin
      stall_q   <= state_q == SLIDE && !win_ready && stall_q != 16'hFFFF ? stall_q + 16'd1 : stall_q;
      memwait_q <= state_q == LOAD_WAIT && !mem_rvalid && memwait_q != 16'hFFFF ? memwait_q + 16'd1 : memwait_q;
    end
  end
  assign stall_cnt   = stall_q;
  assign memwait_cnt = memwait_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_window_buffer_ctrl.sv
// tb_window_buffer_ctrl: randomized scoreboard bench with a row/band reference model and latency-varying memory
module tb_window_buffer_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mem_rvalid = 1'b0, win_ready = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0] num_rows = '0;
  logic mem_rd, buf_we, buf_shift_up, win_valid, busy, done, err;
  logic [15:0] mem_addr;
  logic [8:0] buf_addr;
  logic [3:0] win_col;
  logic [7:0] win_row;
`ifdef WINDOW_CTRL_PERF_EN
  logic [15:0] stall_cnt, memwait_cnt;
`endif
  window_buffer_ctrl #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .buf_we(buf_we),
    .buf_shift_up(buf_shift_up), .buf_addr(buf_addr), .win_valid(win_valid), .win_ready(win_ready),
    .win_col(win_col), .win_row(win_row), .busy(busy), .done(done), .err(err)
`ifdef WINDOW_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .memwait_cnt(memwait_cnt)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [15:0] exp_rd[$];
  logic [8:0]  exp_we[$];
  logic [11:0] exp_win[$];
  logic [11:0] e;
  int exp_shift = 0, shift_cnt = 0, done_cnt = 0, cyc = 0, first_win = -1, start_cyc = 0;
  int stalls = 0, mwaits = 0, lmax = 1, mcnt = 0;
  bit exp_err = 0, wait_f = 0, noise = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  // memory: answers each read after 1..lmax cycles; optional stray rvalid while no read is outstanding
  initial forever begin
    @(negedge clk);
    mem_rvalid = 1'b0;
    if (!rst_n) mcnt = 0;
    else begin
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) mem_rvalid = 1'b1;
      end else if (noise && !mem_rd && $urandom_range(0, 4) == 0) mem_rvalid = 1'b1;
      if (mem_rd) mcnt = $urandom_range(1, lmax);
    end
  end

  // monitor: compares every presented output against the scoreboard queues
  initial forever begin
    @(negedge clk);
    #2;
    cyc++;
    if (!rst_n) wait_f = 0;
    else begin
      if (wait_f) begin
        if (mem_rvalid) wait_f = 0;
        else mwaits++;
      end
      if (mem_rd) begin
        wait_f = 1;
        if (exp_rd.size() == 0) fail("unexpected_mem_rd");
        else chk("mem_addr", mem_addr, exp_rd.pop_front());
      end
      if (buf_we) begin
        chk("buf_we_without_rvalid", mem_rvalid, 1);
        if (exp_we.size() == 0) fail("unexpected_buf_we");
        else chk("buf_we_addr", buf_addr, exp_we.pop_front());
      end
      if (buf_we || buf_shift_up) chk("we_shift_exclusive", buf_we & buf_shift_up, 0);
      if (buf_shift_up) shift_cnt++;
      if (win_valid) begin
        if (first_win < 0) first_win = cyc;
        if (!win_ready) stalls++;
        if (exp_win.size() == 0) fail("unexpected_win_valid");
        else begin
          e = exp_win[0];
          chk("win_col", win_col, e[3:0]);
          chk("win_row", win_row, e[11:4]);
          chk("win_buf_addr", buf_addr, {5'b0, e[3:0]});
          if (win_ready) void'(exp_win.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        chk("err_at_done", err, exp_err);
        chk("shift_count", shift_cnt, exp_shift);
        chk("leftover_expected", exp_rd.size() + exp_we.size() + exp_win.size(), 0);
`ifdef WINDOW_CTRL_PERF_EN
        chk("stall_cnt", stall_cnt, stalls);
        chk("memwait_cnt", memwait_cnt, mwaits);
`endif
      end
    end
  end

  // reference model: read addresses, write slots and windows derived from row/band arithmetic
  task automatic issue(input logic [15:0] b, input logic [7:0] n);
    int nn = int'(n);
    if (nn >= 4) begin
      for (int r = 0; r < 4; r++)
        for (int w = 0; w < 4; w++) begin
          exp_rd.push_back(16'(b + r * 4 + w));
          exp_we.push_back(9'(r * 16 + w * 4));
        end
      for (int k = 1; k <= nn - 4; k++)
        for (int w = 0; w < 4; w++) begin
          exp_rd.push_back(16'(b + (k + 3) * 4 + w));
          exp_we.push_back(9'(48 + w * 4));
        end
      for (int k = 0; k <= nn - 4; k++)
        for (int c = 0; c < 13; c++) exp_win.push_back({8'(k), 4'(c)});
    end
    exp_err = nn < 4;
    exp_shift = nn < 4 ? 0 : nn - 4;
    shift_cnt = 0;
    stalls = 0;
    mwaits = 0;
    first_win = -1;
    start_cyc = cyc + 1;
    base_addr = b;
    num_rows = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [15:0] b, input logic [7:0] n, input int pct, input bit bp, input bit stray);
    int hold = 0, t = 0, d0 = done_cnt;
    win_ready = 1'b1;
    issue(b, n);
    while (done_cnt == d0 && t < 5000) begin
      start = 1'b0;
      if (bp) begin
        if (win_valid && win_col == 4'd7 && hold < 5) begin
          win_ready = 1'b0;
          hold++;
        end else win_ready = 1'b1;
      end else win_ready = $urandom_range(0, 99) < pct;
      if (stray && busy && $urandom_range(0, 9) == 0) begin
        start = 1'b1;
        base_addr = 16'($urandom);
        num_rows = 8'($urandom);
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    if (t >= 5000) fail("timeout_waiting_done");
  endtask

  initial begin
    #3;
    chk("reset_outputs", {mem_rd, mem_addr, buf_we, buf_shift_up, buf_addr, win_valid, win_col, win_row, busy, done, err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lmax = 1;
    run(16'h0100, 8'd4, 100, 0, 0);
    chk("first_window_latency", first_win - start_cyc, 33);
    run(16'h0000, 8'd6, 100, 0, 0);
    run(16'h0200, 8'd5, 100, 1, 0);
    run(16'h0300, 8'd2, 100, 0, 0);
    @(negedge clk);
    chk("err_sticky", err, 1);
    lmax = 4;
    noise = 1;
    run(16'($urandom), 8'd7, 70, 0, 1);
    for (int i = 0; i < 4; i++) begin
      lmax = $urandom_range(1, 4);
      run(16'($urandom_range(16'hFFC0, 16'hFFFF)), 8'($urandom_range(4, 10)), 70, 0, 1);
    end
    noise = 0;
    lmax = 2;
    begin
      int t = 0;
      win_ready = 1'b1;
      issue(16'h0400, 8'd8);
      while (!(win_row == 8'd1 && mem_rd && mem_addr == 16'h0412) && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) fail("timeout_waiting_refill");
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {mem_rd, mem_addr, buf_we, buf_shift_up, buf_addr, win_valid, win_col, win_row, busy, done, err}, 0);
`ifdef WINDOW_CTRL_PERF_EN
      chk("async_reset_perf", {stall_cnt, memwait_cnt}, 0);
`endif
      exp_rd.delete();
      exp_we.delete();
      exp_win.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end
    run(16'h0400, 8'd8, 80, 0, 1);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
